template_correlator: RTL and testbench

TEMPLATE_CORRELATOR -- requirements
Module: template_correlator

---
 rtl/template_correlator.sv | 234 +++++++++++++++++++++++
 tb/tb_template_correlator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/template_correlator.sv
// Raster-stream template correlator: scores every fully-inside TPL_N x TPL_N window and reports
// the first strictly-best window. Optional threshold match output under `CORR_THRESH_EN.
module template_correlator #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned TPL_N = 3,
    parameter int unsigned PIX_W = 4,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H),
    localparam int unsigned SW = 2 * PIX_W + $clog2(TPL_N * TPL_N)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [TPL_N*TPL_N*PIX_W-1:0]   tpl,
    input  logic                           pix_valid,
    input  logic [PIX_W-1:0]               pix_in,
`ifdef CORR_THRESH_EN
    input  logic [SW-1:0]                  thresh,
    output logic                           match,
`endif
    output logic                           busy,
    output logic                           done,
    output logic [XW-1:0]                  max_x,
    output logic [YW-1:0]                  max_y,
    output logic [SW-1:0]                  max_score
);

    localparam int unsigned NN     = TPL_N * TPL_N;
    localparam int unsigned PW     = 2 * PIX_W;
    localparam int unsigned LB_LEN = (TPL_N - 1) * IMG_W + TPL_N - 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              drain_q, drain_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [PIX_W-1:0]  tpl_q [NN];
    logic [PIX_W-1:0]  tpl_d [NN];
    logic [PIX_W-1:0]  lb_q [LB_LEN];
    logic [PIX_W-1:0]  lb_d [LB_LEN];
    logic [PIX_W-1:0]  win [NN];
    logic [PW-1:0]     prod_q [NN];
    logic [PW-1:0]     prod_d [NN];
    logic              s1_valid_q, s1_valid_d;
    logic [XW-1:0]     s1_x_q, s1_x_d;
    logic [YW-1:0]     s1_y_q, s1_y_d;
    logic              s2_valid_q, s2_valid_d;
    logic [XW-1:0]     s2_x_q, s2_x_d;
    logic [YW-1:0]     s2_y_q, s2_y_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [XW-1:0]     max_x_q, max_x_d;
    logic [YW-1:0]     max_y_q, max_y_d;
    logic [SW-1:0]     max_score_q, max_score_d;

    logic              accept, scoring, last_pix;
    logic [XW-1:0]     x_cur;
    logic [YW-1:0]     y_cur;

    // A start cycle treats its own pixel as (0,0) of the new frame.
    always_comb begin
        x_cur    = start ? '0 : x_q;
        y_cur    = start ? '0 : y_q;
        accept   = pix_valid && (start || state_q == StRun);
        scoring  = accept && (x_cur >= XW'(TPL_N - 1)) && (y_cur >= YW'(TPL_N - 1));
        last_pix = accept && (x_cur == XW'(IMG_W - 1)) && (y_cur == YW'(IMG_H - 1));
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (start) begin
            state_d = StRun;
            drain_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    if (last_pix) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end
                end
                StDrain: begin
                    drain_d = 1'b1;
                    if (drain_q) begin
                        state_d = StDone;
                        drain_d = 1'b0;
                    end
                end
                StDone: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        x_d = start ? '0 : x_q;
        y_d = start ? '0 : y_q;
        if (accept) begin
            if (x_cur == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_cur == YW'(IMG_H - 1)) ? '0 : y_cur + YW'(1);
            end else begin
                x_d = x_cur + XW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            tpl_d[i] = start ? tpl[i*PIX_W +: PIX_W] : tpl_q[i];
        end
        lb_d = lb_q;
        if (accept) begin
            lb_d[0] = pix_in;
            for (int k = 1; k < LB_LEN; k++) begin
                lb_d[k] = lb_q[k-1];
            end
        end
    end

    // Tap k pixels back in accepted order; tap 0 is the pixel being accepted now.
    for (genvar gi = 0; gi < NN; gi++) begin : g_win
        localparam int unsigned R = gi / TPL_N;
        localparam int unsigned C = gi % TPL_N;
        localparam int unsigned K = (TPL_N - 1 - R) * IMG_W + (TPL_N - 1 - C);
        if (K == 0) begin : g_cur
            assign win[gi] = pix_in;
        end else begin : g_tap
            assign win[gi] = lb_q[K-1];
        end
    end

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            prod_d[i] = PW'(tpl_q[i]) * PW'(win[i]);
        end
        s1_valid_d = scoring;
        s1_x_d     = x_cur - XW'(TPL_N - 1);
        s1_y_d     = y_cur - YW'(TPL_N - 1);

        sum_d = '0;
        for (int i = 0; i < NN; i++) begin
            sum_d = sum_d + SW'(prod_q[i]);
        end
        s2_valid_d = s1_valid_q && !start;
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;

        max_x_d     = max_x_q;
        max_y_d     = max_y_q;
        max_score_d = max_score_q;
        if (start) begin
            max_x_d     = '0;
            max_y_d     = '0;
            max_score_d = '0;
        end else if (s2_valid_q && (sum_q > max_score_q)) begin
            max_x_d     = s2_x_q;
            max_y_d     = s2_y_q;
            max_score_d = sum_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            drain_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            max_x_q     <= '0;
            max_y_q     <= '0;
            max_score_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            x_q         <= x_d;
            y_q         <= y_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            max_x_q     <= max_x_d;
            max_y_q     <= max_y_d;
            max_score_q <= max_score_d;
        end
    end

    // Data-only storage; qualified by the valid tags above.
    always_ff @(posedge clk) begin
        tpl_q  <= tpl_d;
        lb_q   <= lb_d;
        prod_q <= prod_d;
        s1_x_q <= s1_x_d;
        s1_y_q <= s1_y_d;
        sum_q  <= sum_d;
        s2_x_q <= s2_x_d;
        s2_y_q <= s2_y_d;
    end

`ifdef CORR_THRESH_EN
    logic [SW-1:0] thresh_q, thresh_d;
    logic          match_q, match_d;

    always_comb begin
        thresh_d = start ? thresh : thresh_q;
        match_d  = match_q;
        if (start) begin
            match_d = 1'b0;
        end else if (state_q == StDrain && drain_q) begin
            match_d = (max_score_d >= thresh_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            thresh_q <= '0;
            match_q  <= 1'b0;
        end else begin
            thresh_q <= thresh_d;
            match_q  <= match_d;
        end
    end

    assign match = match_q;
`endif

    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign max_x     = max_x_q;
    assign max_y     = max_y_q;
    assign max_score = max_score_q;

endmodule

// File: tb/tb_template_correlator.sv
// Bench for template_correlator: directed corner cases plus random frames against a brute-force
// window-search model. Threshold checks compile in when CORR_THRESH_EN is defined.
module tb_template_correlator;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int N    = 3;
    localparam int PIXW = 4;
    localparam int XW   = $clog2(W);
    localparam int YW   = $clog2(H);
    localparam int SW   = 2 * PIXW + $clog2(N * N);
    localparam int TW   = N * N * PIXW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [TW-1:0]   tpl_v = '0;
    logic            pix_valid = 1'b0;
    logic [PIXW-1:0] pix_in = '0;
    logic            busy, done;
    logic [XW-1:0]   max_x;
    logic [YW-1:0]   max_y;
    logic [SW-1:0]   max_score;
`ifdef CORR_THRESH_EN
    logic [SW-1:0]   thresh_in = '0;
    logic            match;
`endif

    template_correlator #(
        .IMG_W(W), .IMG_H(H), .TPL_N(N), .PIX_W(PIXW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tpl       (tpl_v),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
`ifdef CORR_THRESH_EN
        .thresh    (thresh_in),
        .match     (match),
`endif
        .busy      (busy),
        .done      (done),
        .max_x     (max_x),
        .max_y     (max_y),
        .max_score (max_score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    int unsigned img [W*H];
    int unsigned tpl_a [N*N];

    int            r_lat;
    logic          r_got, r_busy, r_done_after, r_match;
    logic [SW-1:0] r_score;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    // Exhaustive search over in-image windows in raster order, strict improvement only.
    task automatic model(output int unsigned bs, output int unsigned bx, output int unsigned by);
        bs = 0; bx = 0; by = 0;
        for (int y0 = 0; y0 <= H - N; y0++) begin
            for (int x0 = 0; x0 <= W - N; x0++) begin
                int unsigned s = 0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        s += tpl_a[r*N+c] * img[(y0+r)*W + x0 + c];
                if (s > bs) begin bs = s; bx = x0; by = y0; end
            end
        end
    endtask

    task automatic run_frame(input int gap_pct);
        int idx;
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < N*N; i++) tpl_v[i*PIXW +: PIXW] = PIXW'(tpl_a[i]);
        start = 1'b1; pix_valid = 1'b1; pix_in = PIXW'(img[0]); idx = 1;
        while (idx < W*H) begin
            @(posedge clk); #1;
            start = 1'b0;
            tpl_v = TW'({$urandom, $urandom});
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                pix_valid = 1'b0; pix_in = PIXW'($urandom);
            end else begin
                pix_valid = 1'b1; pix_in = PIXW'(img[idx]); idx++;
            end
        end
        n = 0; r_got = 1'b0; r_busy = 1'b0;
        while (n < 20 && !r_got) begin
            @(posedge clk); #1;
            pix_valid = 1'b0; pix_in = PIXW'($urandom);
            n++;
            if (n == 1) r_busy = busy;
            if (done === 1'b1) r_got = 1'b1;
        end
        r_lat = n; r_score = max_score; r_x = max_x; r_y = max_y;
`ifdef CORR_THRESH_EN
        r_match = match;
`else
        r_match = 1'b0;
`endif
        @(posedge clk); #1;
        r_done_after = done;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < W*H; i++) img[i] = 0;
        for (int i = 0; i < N*N; i++) tpl_a[i] = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (max_x !== '0) begin errors++; $display("FAIL reset_max_x: got %0d want 0", max_x); end
        checks++; if (max_y !== '0) begin errors++; $display("FAIL reset_max_y: got %0d want 0", max_y); end
        checks++; if (max_score !== '0) begin errors++; $display("FAIL reset_score: got %0d want 0", max_score); end
`ifdef CORR_THRESH_EN
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", match); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single_pixel();
        clear_frame();
        for (int i = 0; i < N*N; i++) tpl_a[i] = 1;
        img[3*W+5] = 15;
        run_frame(0);
        checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", r_got); end
        checks++; if (r_lat != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", r_lat); end
        checks++; if (r_score !== SW'(15)) begin errors++; $display("FAIL single_score: got %0d want 15", r_score); end
        checks++; if (r_x !== XW'(3)) begin errors++; $display("FAIL single_x: got %0d want 3", r_x); end
        checks++; if (r_y !== YW'(1)) begin errors++; $display("FAIL single_y: got %0d want 1", r_y); end
        checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", r_busy); end
        checks++; if (r_done_after !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", r_done_after); end
    endtask

    task automatic test_left_edge();
        clear_frame();
        tpl_a[4] = 1;
        img[2*W+0] = 9;
        run_frame(0);
        checks++; if (r_got !== 1'b1) begin errors++; $display("FAIL edge_done: got %b want 1", r_got); end
        checks++; if (r_score !== '0) begin errors++; $display("FAIL edge_score: got %0d want 0", r_score); end
        checks++; if (r_x !== '0 || r_y !== '0) begin
            errors++; $display("FAIL edge_coord: got (%0d,%0d) want (0,0)", r_x, r_y);
        end
    endtask

    task automatic test_tie();
        clear_frame();
        tpl_a[4] = 2;
        img[2*W+2] = 10;
        img[4*W+5] = 10;
        run_frame(0);
        checks++; if (r_score !== SW'(20)) begin errors++; $display("FAIL tie_score: got %0d want 20", r_score); end
        checks++; if (r_x !== XW'(1) || r_y !== YW'(1)) begin
            errors++; $display("FAIL tie_coord: got (%0d,%0d) want (1,1)", r_x, r_y);
        end
    endtask

    task automatic test_random_stream();
        for (int it = 0; it < 3; it++) begin
            int unsigned ms, mx, my;
            logic [SW-1:0] c_score;
            logic [XW-1:0] c_x;
            logic [YW-1:0] c_y;
            for (int i = 0; i < W*H; i++) img[i] = $urandom_range(15);
            for (int i = 0; i < N*N; i++) tpl_a[i] = $urandom_range(15);
            model(ms, mx, my);
            run_frame(0);
            c_score = r_score; c_x = r_x; c_y = r_y;
            checks++; if (r_score !== SW'(ms) || r_x !== XW'(mx) || r_y !== YW'(my)) begin
                errors++;
                $display("FAIL rand_cont: got %0d@(%0d,%0d) want %0d@(%0d,%0d)",
                         r_score, r_x, r_y, ms, mx, my);
            end
            run_frame(50);
            checks++; if (r_score !== c_score || r_x !== c_x || r_y !== c_y) begin
                errors++;
                $display("FAIL rand_gaps: got %0d@(%0d,%0d) want %0d@(%0d,%0d)",
                         r_score, r_x, r_y, c_score, c_x, c_y);
            end
            checks++; if (r_lat != 3) begin errors++; $display("FAIL rand_gaps_latency: got %0d want 3", r_lat); end
        end
    endtask

    task automatic test_abort();
        int unsigned ms, mx, my;
        int cnt0;
        cnt0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; tpl_v = '1; pix_valid = 1'b1; pix_in = '1;
        for (int i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0; pix_in = '1;
        end
        for (int i = 0; i < W*H; i++) img[i] = $urandom_range(7);
        for (int i = 0; i < N*N; i++) tpl_a[i] = $urandom_range(7);
        model(ms, mx, my);
        run_frame(0);
        checks++; if (done_cnt - cnt0 != 1) begin
            errors++; $display("FAIL abort_done_count: got %0d want 1", done_cnt - cnt0);
        end
        checks++; if (r_score !== SW'(ms) || r_x !== XW'(mx) || r_y !== YW'(my)) begin
            errors++;
            $display("FAIL abort_result: got %0d@(%0d,%0d) want %0d@(%0d,%0d)",
                     r_score, r_x, r_y, ms, mx, my);
        end
    endtask

    task automatic test_hold();
        int unsigned ms, mx, my;
        int cnt0;
        model(ms, mx, my);
        cnt0 = done_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1; pix_in = PIXW'($urandom); tpl_v = TW'({$urandom, $urandom});
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        checks++; if (max_score !== SW'(ms) || max_x !== XW'(mx) || max_y !== YW'(my)) begin
            errors++;
            $display("FAIL hold_result: got %0d@(%0d,%0d) want %0d@(%0d,%0d)",
                     max_score, max_x, max_y, ms, mx, my);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b want 0", busy); end
        checks++; if (done_cnt != cnt0) begin errors++; $display("FAIL hold_done: got %0d extra", done_cnt - cnt0); end
    endtask

    task automatic test_reset_mid_frame();
        int cnt0;
        cnt0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; tpl_v = '1; pix_valid = 1'b1; pix_in = '1;
        for (int i = 1; i < 25; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst_n = 1'b0; pix_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (max_score !== '0) begin errors++; $display("FAIL midrst_score: got %0d want 0", max_score); end
        repeat (12) @(posedge clk);
        #1;
        checks++; if (done_cnt != cnt0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", done_cnt - cnt0); end
    endtask

`ifdef CORR_THRESH_EN
    task automatic test_thresh();
        thresh_in = SW'(16);
        clear_frame();
        for (int i = 0; i < N*N; i++) tpl_a[i] = 1;
        img[3*W+5] = 15;
        run_frame(0);
        checks++; if (r_match !== 1'b0) begin errors++; $display("FAIL thresh_below: got %b want 0", r_match); end
        clear_frame();
        for (int i = 0; i < N*N; i++) tpl_a[i] = 2;
        img[3*W+5] = 8;
        run_frame(0);
        checks++; if (r_score !== SW'(16)) begin errors++; $display("FAIL thresh_score: got %0d want 16", r_score); end
        checks++; if (r_match !== 1'b1) begin errors++; $display("FAIL thresh_equal: got %b want 1", r_match); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL thresh_hold: got %b want 1", match); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_pixel();
        test_left_edge();
        test_tie();
        test_random_stream();
        test_abort();
        test_hold();
        test_reset_mid_frame();
`ifdef CORR_THRESH_EN
        test_thresh();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
